// File: rtl/fetch_unit.sv
// fetch_unit -- PC register and instruction-fetch sequencer for the LEGv8 datapath.
//
// Holds CurrentPC, fetches the word at CurrentPC over a request/grant/response
// handshake, presents it to decode with valid/accept, loads NextPC when decode
// accepts, flags misaligned PCs (sticky until reset), and counts retired fetches.
//
// Ports:
//   CLK           in   1   clock, rising edge
//   Reset         in   1   synchronous active-high reset
//   NextPC        in  64   next PC, sampled only at an accept edge
//   CurrentPC     out 64   PC register
//   IMemReq       out  1   fetch request
//   IMemAddr      out 64   fetch address (= CurrentPC)
//   IMemGnt       in   1   memory accepted the request this cycle
//   IMemRdValid   in   1   read data valid
//   IMemRdData    in  32   instruction word
//   Instruction   out 32   latched instruction
//   InstrValid    out  1   Instruction valid for decode
//   InstrAccept   in   1   decode consumes Instruction
//   Fault         out  1   sticky misaligned-PC flag
//   RetiredCount  out 32   accepted-instruction count, wraps at 2^32
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] NextPC,
  output logic [63:0] CurrentPC,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRdValid,
  input  logic [31:0] IMemRdData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        InstrAccept,
  output logic        Fault,
  output logic [31:0] RetiredCount
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_READY,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic        drain_q, drain_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  // Request is suppressed while a pre-reset response is still in flight.
  logic req_int;
  assign req_int = (state_q == S_FETCH) && !drain_q;

  assign IMemReq      = req_int && !Reset;
  assign InstrValid   = (state_q == S_READY) && !Reset;
  assign Fault        = (state_q == S_FAULT);
  assign CurrentPC    = pc_q;
  assign IMemAddr     = pc_q;
  assign Instruction  = instr_q;
  assign RetiredCount = count_q;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;

    case (state_q)
      S_FETCH: begin
        if (req_int && IMemGnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (IMemRdValid) begin
          instr_d = IMemRdData;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (InstrAccept) begin
          pc_d    = NextPC;
          count_d = count_q + 32'd1;
          state_d = (NextPC[1:0] == 2'b00) ? S_FETCH : S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A response arriving outside WAIT is the stale one owed from before
    // reset; swallowing it releases the request. Without a pending drain it
    // is a protocol error and is simply ignored.
    if ((state_q != S_WAIT) && IMemRdValid && drain_q) drain_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_FETCH;
      // Reset in WAIT leaves a response outstanding that must be discarded.
      drain_q <= (state_q == S_WAIT);
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [63:0] RPC = 64'h400;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] NextPC = '0;
  logic        IMemGnt = 1'b0;
  logic        IMemRdValid = 1'b0;
  logic [31:0] IMemRdData = '0;
  logic        InstrAccept = 1'b0;

  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Fault;
  logic [31:0] RetiredCount;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .NextPC       (NextPC),
    .CurrentPC    (CurrentPC),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemGnt      (IMemGnt),
    .IMemRdValid  (IMemRdValid),
    .IMemRdData   (IMemRdData),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .InstrAccept  (InstrAccept),
    .Fault        (Fault),
    .RetiredCount (RetiredCount)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks whether a request is outstanding, whether
  // an instruction is held for decode, whether a stale response is owed, and
  // whether the unit has faulted.
  logic [63:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_count = '0;
  bit          m_have  = 1'b0;
  bit          m_out   = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_fault = 1'b0;

  always @(posedge CLK) begin
    if (Reset) begin
      m_drain = m_out;
      m_out   = 1'b0;
      m_have  = 1'b0;
      m_fault = 1'b0;
      m_pc    = RPC;
      m_instr = '0;
      m_count = '0;
    end else if (m_fault) begin
      // stuck until reset
    end else if (m_have) begin
      if (InstrAccept) begin
        m_pc    = NextPC;
        m_count = m_count + 32'd1;
        m_have  = 1'b0;
        if (NextPC[1:0] != 2'b00) m_fault = 1'b1;
      end
    end else if (m_out) begin
      if (IMemRdValid) begin
        m_instr = IMemRdData;
        m_have  = 1'b1;
        m_out   = 1'b0;
      end
    end else if (m_drain) begin
      if (IMemRdValid) m_drain = 1'b0;
    end else if (IMemGnt) begin
      m_out = 1'b1;
    end

    #2;
    chk64("cyc_CurrentPC", CurrentPC, m_pc);
    chk64("cyc_IMemAddr", IMemAddr, m_pc);
    chk1("cyc_IMemReq", IMemReq, !Reset && !m_fault && !m_have && !m_out && !m_drain);
    chk1("cyc_InstrValid", InstrValid, !Reset && m_have);
    chk32("cyc_Instruction", Instruction, m_instr);
    chk1("cyc_Fault", Fault, m_fault);
    chk32("cyc_RetiredCount", RetiredCount, m_count);
    if (Instruction === 32'hDEADBEEF) begin
      n_miss++;
      $display("FAIL stale_instr: got %h required anything but deadbeef", Instruction);
    end
  end

  initial begin
    // Reset with RESET_PC = 0x400
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk64("rst_pc", CurrentPC, 64'h400);
    chk64("rst_addr", IMemAddr, 64'h400);
    chk1("rst_req", IMemReq, 1'b1);
    chk1("rst_valid", InstrValid, 1'b0);
    chk32("rst_count", RetiredCount, 32'd0);
    chk1("rst_fault", Fault, 1'b0);
    chk32("rst_instr", Instruction, 32'd0);

    // Zero-wait fetch, accept immediately
    IMemGnt = 1'b1;
    @(negedge CLK);
    chk1("zw_req_wait", IMemReq, 1'b0);
    IMemGnt = 1'b0; IMemRdValid = 1'b1; IMemRdData = 32'h8B020020;
    @(negedge CLK);
    chk1("zw_valid", InstrValid, 1'b1);
    chk32("zw_instr", Instruction, 32'h8B020020);
    IMemRdValid = 1'b0; InstrAccept = 1'b1; NextPC = 64'h404;
    @(negedge CLK);
    chk1("zw_valid_drop", InstrValid, 1'b0);
    chk64("zw_pc", CurrentPC, 64'h404);
    chk32("zw_count", RetiredCount, 32'd1);
    chk1("zw_req", IMemReq, 1'b1);

    // Grant delayed 3 cycles; stray accept and stray response are ignored
    InstrAccept = 1'b1; NextPC = 64'hBAD0;
    IMemRdValid = 1'b1; IMemRdData = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk1("gd_req", IMemReq, 1'b1);
      chk64("gd_addr", IMemAddr, 64'h404);
      IMemRdValid = 1'b0;
    end
    InstrAccept = 1'b0; IMemGnt = 1'b1;
    @(negedge CLK);
    IMemGnt = 1'b0; IMemRdValid = 1'b1; IMemRdData = 32'hF8400020;
    @(negedge CLK);
    IMemRdValid = 1'b0; IMemGnt = 1'b1;
    // Accept withheld 5 cycles; grant offered meanwhile must not start a fetch
    for (int i = 0; i < 5; i++) begin
      chk1("ad_valid", InstrValid, 1'b1);
      chk32("ad_instr", Instruction, 32'hF8400020);
      chk64("ad_pc", CurrentPC, 64'h404);
      chk1("ad_req", IMemReq, 1'b0);
      @(negedge CLK);
    end
    IMemGnt = 1'b0; InstrAccept = 1'b1; NextPC = 64'h408;
    @(negedge CLK);
    InstrAccept = 1'b0;
    chk64("ad_pc_new", CurrentPC, 64'h408);
    chk32("ad_count", RetiredCount, 32'd2);
    chk1("ad_req_new", IMemReq, 1'b1);

    // Misaligned NextPC -> sticky fault
    IMemGnt = 1'b1;
    @(negedge CLK);
    IMemGnt = 1'b0; IMemRdValid = 1'b1; IMemRdData = 32'hD503201F;
    @(negedge CLK);
    IMemRdValid = 1'b0; InstrAccept = 1'b1; NextPC = 64'h406;
    @(negedge CLK);
    chk1("flt_fault", Fault, 1'b1);
    chk64("flt_pc", CurrentPC, 64'h406);
    chk32("flt_count", RetiredCount, 32'd3);
    IMemGnt = 1'b1; NextPC = 64'h500;
    for (int i = 0; i < 20; i++) begin
      IMemRdValid = i[0];
      @(negedge CLK);
      chk1("flt_req", IMemReq, 1'b0);
      chk1("flt_valid", InstrValid, 1'b0);
      chk1("flt_sticky", Fault, 1'b1);
    end
    IMemGnt = 1'b0; IMemRdValid = 1'b0; InstrAccept = 1'b0;
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk1("flt_clear", Fault, 1'b0);
    chk64("flt_rst_pc", CurrentPC, 64'h400);
    chk1("flt_rst_req", IMemReq, 1'b1);

    // Reset in READY with accept high: instruction dropped, count not bumped
    IMemGnt = 1'b1;
    @(negedge CLK);
    IMemGnt = 1'b0; IMemRdValid = 1'b1; IMemRdData = 32'h12345678;
    @(negedge CLK);
    IMemRdValid = 1'b0;
    chk1("rr_valid", InstrValid, 1'b1);
    Reset = 1'b1; InstrAccept = 1'b1; NextPC = 64'h800;
    #1;
    chk1("rr_valid_in_reset", InstrValid, 1'b0);
    @(negedge CLK);
    Reset = 1'b0; InstrAccept = 1'b0;
    #1;
    chk32("rr_count", RetiredCount, 32'd0);
    chk64("rr_pc", CurrentPC, 64'h400);
    chk32("rr_instr", Instruction, 32'd0);

    // Reset in WAIT: stale response 4 cycles after release is discarded
    IMemGnt = 1'b1;
    @(negedge CLK);
    IMemGnt = 1'b0;
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    IMemGnt = 1'b1;
    #1;
    chk1("rw_drain_req", IMemReq, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk1("rw_drain_req", IMemReq, 1'b0);
    end
    IMemRdValid = 1'b1; IMemRdData = 32'hDEADBEEF;
    @(negedge CLK);
    IMemRdValid = 1'b0;
    chk1("rw_req", IMemReq, 1'b1);
    chk64("rw_addr", IMemAddr, 64'h400);
    chk32("rw_instr", Instruction, 32'd0);
    @(negedge CLK);
    IMemGnt = 1'b0; IMemRdValid = 1'b1; IMemRdData = 32'h91000421;
    @(negedge CLK);
    IMemRdValid = 1'b0;
    chk32("rw_new_instr", Instruction, 32'h91000421);
    InstrAccept = 1'b1; NextPC = 64'h404;
    @(negedge CLK);
    InstrAccept = 1'b0;
    chk32("rw_count", RetiredCount, 32'd1);

    // Retired count wrap at 2^32
    force dut.count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    IMemGnt = 1'b1;
    @(negedge CLK);
    chk32("wr_preload", RetiredCount, 32'hFFFF_FFFF);
    IMemGnt = 1'b0; IMemRdValid = 1'b1; IMemRdData = 32'hAA0003E0;
    @(negedge CLK);
    IMemRdValid = 1'b0; InstrAccept = 1'b1; NextPC = 64'h408;
    @(negedge CLK);
    InstrAccept = 1'b0;
    chk32("wr_wrap", RetiredCount, 32'd0);
    chk64("wr_pc", CurrentPC, 64'h408);

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
